// File: rtl/fetch_buffer_pkg.sv
// Shared types and sizing for the instruction fetch buffer.
package fetch_buffer_pkg;

   localparam int unsigned IW          = 9;
   localparam int unsigned AW          = 10;
   localparam int unsigned kFetchDepth = 4;

   // One queued fetch: the instruction and the PC it was read from.
   typedef struct packed {
      logic [AW-1:0] pc;
      logic [IW-1:0] instr;
   } fb_entry_t;

endpackage : fetch_buffer_pkg

// File: rtl/fb_fifo.sv
// Small circular queue of fetch entries with a synchronous flush.
module fb_fifo
   import fetch_buffer_pkg::*;
#(
   parameter int unsigned DEPTH = kFetchDepth
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_flush,
   input  logic                   i_push,
   input  logic                   i_pop,
   input  fb_entry_t              i_wdata,
   output fb_entry_t              o_rdata,
   output logic [$clog2(DEPTH):0] o_count,
   output logic                   o_full,
   output logic                   o_empty
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   fb_entry_t         r_mem [DEPTH];
   logic [PW-1:0]     r_wr_ptr;
   logic [PW-1:0]     r_rd_ptr;
   logic [CW-1:0]     r_count;
   logic              w_push;
   logic              w_pop;

   // Qualify requests so the queue can never overflow or underflow.
   always_comb begin
      o_full  = (r_count == CW'(DEPTH));
      o_empty = (r_count == '0);
      w_push  = i_push && !o_full && !i_flush;
      w_pop   = i_pop && !o_empty && !i_flush;
      o_count = r_count;
      o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];
   end

   // Entry storage; contents are don't-care until the count covers them.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_wdata;
      end
   end

   // Pointers and occupancy; flush empties the queue in one edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule : fb_fifo

// File: rtl/fetch_buffer.sv
// Fetch stage: owns the fetch PC, reads InstROM and queues {pc, instr} for decode.
module fetch_buffer
   import fetch_buffer_pkg::*;
#(
   parameter int unsigned DEPTH = kFetchDepth
) (
   input  logic                   CLK,
   input  logic                   reset_n,
   input  logic                   init,
   output logic [AW-1:0]          rom_addr,
   input  logic [IW-1:0]          rom_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [IW-1:0]          out_instr,
   output logic [AW-1:0]          out_pc,
   input  logic                   redirect,
   input  logic [AW-1:0]          redirect_pc,
   input  logic                   halt,
   output logic [$clog2(DEPTH):0] count
);

   logic [AW-1:0]          r_fpc;
   logic                   w_full;
   logic                   w_empty;
   logic                   w_flush;
   logic                   w_push;
   logic                   w_pop;
   fb_entry_t              w_wdata;
   fb_entry_t              w_head;
   logic [$clog2(DEPTH):0] w_count;

   // Handshake glue; full is sampled before any same-edge pop.
   always_comb begin
      w_flush      = init || redirect;
      w_push       = !w_full && !halt && !w_flush;
      w_pop        = out_valid && out_ready;
      w_wdata.pc   = r_fpc;
      w_wdata.instr = rom_data;
      rom_addr     = r_fpc;
      out_valid    = !w_empty;
      out_pc       = w_head.pc;
      out_instr    = w_head.instr;
      count        = w_count;
   end

   // Fetch PC: init beats redirect, which beats normal advance.
   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         r_fpc <= '0;
      end else if (init) begin
         r_fpc <= '0;
      end else if (redirect) begin
         r_fpc <= redirect_pc;
      end else if (w_push) begin
         r_fpc <= r_fpc + AW'(1);
      end
   end

   fb_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (CLK),
      .rst_n   (reset_n),
      .i_flush (w_flush),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_wdata (w_wdata),
      .o_rdata (w_head),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

endmodule : fetch_buffer
